// File: rtl/bcd_pkg.sv
// Shared BCD constants and digit type for the decimal adder family.
package bcd_pkg;

    localparam int BCD_W    = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef logic [BCD_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_add_comb.sv
// Combinational single-digit BCD adder core, reusable in ripple chains.
module bcd_digit_add_comb
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       err
);

    logic [4:0] raw;
    logic [4:0] corrected;

    always_comb begin
        raw       = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        // Only the low nibble of the corrected sum is kept, so 5-bit wrap is harmless.
        corrected = raw + 5'(BCD_CORR);
        s         = raw[3:0];
        cout      = 1'b0;
        if (raw > 5'(BCD_MAX)) begin
            s    = corrected[3:0];
            cout = 1'b1;
        end
        err = (a > 4'(BCD_MAX)) | (b > 4'(BCD_MAX));
    end

endmodule

// File: rtl/adder_1digit.sv
// Single-digit BCD adder with one registered output stage and valid tracking.
module adder_1digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       out_valid,
    output logic       err
);

    bcd_digit_t s_p0;
    logic       cout_p0;
    logic       err_p0;

    bcd_digit_add_comb u_core (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s_p0),
        .cout (cout_p0),
        .err  (err_p0)
    );

    // p0 -> output register; data holds when no new operation arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= s_p0;
                cout <= cout_p0;
                err  <= err_p0;
            end
        end
    end

endmodule

// File: tb/tb_adder_1digit.sv
// Self-checking bench for adder_1digit and a three-digit ripple of its core.
module tb_adder_1digit;
    import bcd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       out_valid;
    logic       err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    adder_1digit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid),
        .err       (err)
    );

    // Three-digit ripple chain built from the combinational core
    logic [3:0] ca [3];
    logic [3:0] cb [3];
    logic [3:0] cs [3];
    logic [2:0] ce;
    logic [3:0] cc;
    logic       chain_cin;

    assign cc[0] = chain_cin;

    for (genvar i = 0; i < 3; i++) begin : g_chain
        bcd_digit_add_comb u_digit (
            .a    (ca[i]),
            .b    (cb[i]),
            .cin  (cc[i]),
            .s    (cs[i]),
            .cout (cc[i+1]),
            .err  (ce[i])
        );
    end

    // Reference: decimal arithmetic for legal digits, literal correction rule otherwise.
    function automatic logic [5:0] model(input int ai, input int bi, input int ci);
        int  total;
        int  sv;
        logic c;
        total = ai + bi + ci;
        if (ai <= 9 && bi <= 9) begin
            sv = total % 10;
            c  = (total >= 10);
        end else if (total > 9) begin
            sv = (total + 6) % 16;
            c  = 1'b1;
        end else begin
            sv = total;
            c  = 1'b0;
        end
        model = {(ai > 9 || bi > 9), c, 4'(sv)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 4'd9; b = 4'd9; cin = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, err, cout, s} !== 7'b0) begin
                fails++;
                $display("FAIL reset_hold: got v=%0b e=%0b c=%0b s=%0d, want all 0", out_valid, err, cout, s);
            end
        end
        rst = 1'b0; a = 4'd1; b = 4'd1;
        @(negedge clk);
        checks++;
        if ({out_valid, err, cout, s} !== {3'b100, 4'd2}) begin
            fails++;
            $display("FAIL reset_release: got v=%0b e=%0b c=%0b s=%0d, want v=1 e=0 c=0 s=2", out_valid, err, cout, s);
        end
        // Operation presented together with reset must be dropped
        rst = 1'b1; a = 4'd3; b = 4'd4;
        @(negedge clk);
        checks++;
        if ({out_valid, err, cout, s} !== 7'b0) begin
            fails++;
            $display("FAIL reset_midstream: got v=%0b e=%0b c=%0b s=%0d, want all 0", out_valid, err, cout, s);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_table(input string name, input int tbl[4][3], input int n);
        logic [5:0] exp;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            a = 4'(tbl[k][0]); b = 4'(tbl[k][1]); cin = tbl[k][2][0];
            exp = model(tbl[k][0], tbl[k][1], tbl[k][2]);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({out_valid, err, cout, s} !== {1'b1, exp}) begin
                fails++;
                $display("FAIL %s %0d+%0d+%0d: got v=%0b e=%0b c=%0b s=%0d, want v=1 e=%0b c=%0b s=%0d",
                         name, tbl[k][0], tbl[k][1], tbl[k][2], out_valid, err, cout, s, exp[5], exp[4], exp[3:0]);
            end
        end
    endtask

    task automatic test_simple();
        int tbl[4][3] = '{'{0, 5, 0}, '{0, 2, 0}, '{1, 2, 0}, '{3, 3, 1}};
        test_table("simple", tbl, 4);
    endtask

    task automatic test_carry();
        int tbl[4][3] = '{'{9, 9, 0}, '{9, 9, 1}, '{9, 0, 1}, '{4, 5, 0}};
        test_table("carry", tbl, 4);
        // Boundary values stated directly, independent of the model
        in_valid = 1'b1; a = 4'd9; b = 4'd0; cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({cout, s} !== {1'b1, 4'd0}) begin
            fails++;
            $display("FAIL carry_ten: got c=%0b s=%0d, want c=1 s=0", cout, s);
        end
    endtask

    task automatic test_chain_one(input int av, input int bv, input int ci);
        int got;
        int exp;
        for (int i = 0; i < 3; i++) begin
            ca[i] = 4'((av / (10 ** i)) % 10);
            cb[i] = 4'((bv / (10 ** i)) % 10);
        end
        chain_cin = ci[0];
        #1;
        got = int'(cc[3]) * 1000 + int'(cs[2]) * 100 + int'(cs[1]) * 10 + int'(cs[0]);
        exp = av + bv + ci;
        checks++;
        if (got !== exp || ce !== 3'b000) begin
            fails++;
            $display("FAIL chain %0d+%0d+%0d: got %0d err=%b, want %0d err=000", av, bv, ci, got, ce, exp);
        end
    endtask

    task automatic test_chain();
        test_chain_one(999, 999, 0);
        test_chain_one(999, 999, 1);
        test_chain_one(100, 225, 0);
        for (int k = 0; k < 20; k++)
            test_chain_one(int'($urandom_range(999)), int'($urandom_range(999)), int'($urandom_range(1)));
    endtask

    task automatic test_back_to_back();
        int  prev;
        bit  have = 0;
        @(negedge clk);
        for (int ai = 0; ai < 10; ai++)
            for (int bi = 0; bi < 10; bi++)
                for (int ci = 0; ci < 2; ci++) begin
                    in_valid = 1'b1; a = 4'(ai); b = 4'(bi); cin = ci[0];
                    @(negedge clk);
                    if (have) begin end
                    prev = ai + bi + ci;
                    have = 1;
                    checks++;
                    if (out_valid !== 1'b1 || err !== 1'b0 || s > 4'd9 ||
                        int'(cout) * 10 + int'(s) !== prev) begin
                        fails++;
                        $display("FAIL sweep %0d+%0d+%0d: got v=%0b e=%0b c=%0b s=%0d, want v=1 e=0 total=%0d",
                                 ai, bi, ci, out_valid, err, cout, s, prev);
                    end
                end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; a = 4'd12; b = 4'd3; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = 4'd1; b = 4'd1;
        checks++;
        if ({out_valid, err, cout, s} !== {3'b111, 4'd5}) begin
            fails++;
            $display("FAIL illegal: got v=%0b e=%0b c=%0b s=%0d, want v=1 e=1 c=1 s=5", out_valid, err, cout, s);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, err, cout, s} !== {3'b011, 4'd5}) begin
            fails++;
            $display("FAIL illegal_hold: got v=%0b e=%0b c=%0b s=%0d, want v=0 e=1 c=1 s=5", out_valid, err, cout, s);
        end
    endtask

    task automatic test_random();
        logic [5:0] held;
        logic       exp_v;
        int         ai, bi, ci;
        held  = {err, cout, s};
        exp_v = out_valid;
        for (int k = 0; k < 200; k++) begin
            ai = int'($urandom_range(15));
            bi = int'($urandom_range(15));
            ci = int'($urandom_range(1));
            in_valid = ($urandom_range(3) != 0);
            a = 4'(ai); b = 4'(bi); cin = ci[0];
            if (in_valid) held = model(ai, bi, ci);
            exp_v = in_valid;
            @(negedge clk);
            checks++;
            if ({out_valid, err, cout, s} !== {exp_v, held}) begin
                fails++;
                $display("FAIL random %0d: got v=%0b e=%0b c=%0b s=%0d, want v=%0b e=%0b c=%0b s=%0d",
                         k, out_valid, err, cout, s, exp_v, held[5], held[4], held[3:0]);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; a = 4'd9; b = 4'd9; cin = 1'b0;
        chain_cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ca[i] = 4'd0;
            cb[i] = 4'd0;
        end
        test_reset();
        test_simple();
        test_carry();
        test_chain();
        test_back_to_back();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
